support_ram_loader: RTL

// - Framed byte-stream loader that writes host-supplied images into the support CPU RAM.
// - Sits upstream of the support RAM write port and drives sys_en/sys_A/sys_data/sys_wr.
// - Holds the support CPU off the RAM (sys_en=1) for the duration of each frame.
// - Checks an 8-bit checksum.
// - Frame format: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CSUM.

---
 rtl/support_ram_loader_pkg.sv | 31 +++
 rtl/support_ram_loader_timeout.sv | 33 +++
 rtl/support_ram_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/support_ram_loader_pkg.sv
// Shared definitions for the support RAM loader.
//   - state_t        : frame parser states (3-bit encoding, ST_IDLE..ST_CSUM)
//   - wr_req_t       : one RAM write (address + data) as driven onto sys_A/sys_data
//   - DEF_SYNC_BYTE  : default frame start marker
//   - DEF_TIMEOUT_CYCLES : default inter-byte idle limit inside a frame
//   - csum_add       : modulo-256 running checksum step
package support_ram_loader_pkg;

  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd50000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_LEN_H  = 3'd3,
    ST_LEN_L  = 3'd4,
    ST_DATA   = 3'd5,
    ST_CSUM   = 3'd6
  } state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  data;
  } wr_req_t;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/support_ram_loader_timeout.sv
// Inter-byte idle counter for the loader.
//   clk, nreset : clock, async active-low reset
//   clear       : zero the counter (a byte was accepted, or no frame is open)
//   enable      : count this cycle (a frame is open)
//   expire      : this cycle is the LIMIT-th consecutive idle cycle; the
//                 parent aborts the frame on the same edge
// clear wins over expire, so a byte arriving on the expiring cycle keeps the
// frame alive.
module support_loader_timeout
  import support_ram_loader_pkg::*;
#(
  parameter logic [31:0] LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [31:0] cnt;

  // Flag one cycle early so the abort lands on the edge where the count
  // would reach LIMIT.
  assign expire = enable && !clear && (cnt == LIMIT - 32'd1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)              cnt <= '0;
    else if (clear || expire) cnt <= '0;
    else if (enable)          cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/support_ram_loader.sv
// Framed byte-stream loader feeding the support CPU RAM write port.
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CSUM.
// The modulo-256 sum of every byte after SYNC (CSUM included) must be zero.
//   clk, nreset        : clock, async active-low reset
//   rx_data/rx_valid   : byte stream in; rx_ready is always 1 (one byte/clock)
//   sys_en             : loader owns the RAM port for the whole frame
//   sys_A/sys_data/sys_wr : RAM write, one strobe per payload byte, 1-clock latency
//   busy               : frame in progress
//   load_done/load_err : one-cycle result pulses (good checksum / bad or timeout)
module support_ram_loader
  import support_ram_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sys_en,
  output logic [15:0] sys_A,
  output logic [7:0]  sys_data,
  output logic        sys_wr,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  state_t      state;
  wr_req_t     wr;
  logic [7:0]  addr_hi, len_hi, sum, sum_next;
  logic [15:0] addr, count;
  logic        accept, expire;

  assign rx_ready = 1'b1;
  assign accept   = rx_valid;          // rx_ready is constant
  assign busy     = (state != ST_IDLE);
  assign sum_next = csum_add(sum, rx_data);
  assign sys_A    = wr.a;
  assign sys_data = wr.data;

  // Counter is held at zero outside a frame and restarted by every byte.
  support_loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .nreset (nreset),
    .clear  (accept || !busy),
    .enable (busy),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      wr        <= '0;
      addr_hi   <= '0;
      len_hi    <= '0;
      sum       <= '0;
      addr      <= '0;
      count     <= '0;
      sys_en    <= 1'b0;
      sys_wr    <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sys_wr    <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      if (expire) begin
        // Abort; writes already issued stay in RAM.
        state    <= ST_IDLE;
        sys_en   <= 1'b0;
        load_err <= 1'b1;
      end else if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state  <= ST_ADDR_H;
              sum    <= '0;
              sys_en <= 1'b1;
            end
          end
          ST_ADDR_H: begin
            addr_hi <= rx_data;
            sum     <= sum_next;
            state   <= ST_ADDR_L;
          end
          ST_ADDR_L: begin
            addr  <= {addr_hi, rx_data};
            sum   <= sum_next;
            state <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len_hi <= rx_data;
            sum    <= sum_next;
            state  <= ST_LEN_L;
          end
          ST_LEN_L: begin
            count <= {len_hi, rx_data};
            sum   <= sum_next;
            state <= ({len_hi, rx_data} != 16'd0) ? ST_DATA : ST_CSUM;
          end
          ST_DATA: begin
            sys_wr  <= 1'b1;
            wr.a    <= addr;
            wr.data <= rx_data;
            addr    <= addr + 16'd1;   // wraps 0xFFFF -> 0x0000
            count   <= count - 16'd1;
            sum     <= sum_next;
            if (count == 16'd1) state <= ST_CSUM;
          end
          ST_CSUM: begin
            // sys_en drops with the pulse; the last write strobed a cycle earlier.
            sum       <= sum_next;
            load_done <= (sum_next == 8'h00);
            load_err  <= (sum_next != 8'h00);
            sys_en    <= 1'b0;
            state     <= ST_IDLE;
          end
          default: begin
            state  <= ST_IDLE;
            sys_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
